// File: rtl/undo_log_arbiter_pkg.sv
// Shared types for the tile undo-log write path: entry fields, widths and helpers.
package undo_log_arbiter_pkg;

  localparam int LOG_CQ_SLICE_SIZE  = 4;
  localparam int LOG_UNDO_LOG_DEPTH = 2;
  localparam int UNDO_ID_W          = 8;

  typedef logic [UNDO_ID_W-1:0]         undo_id_t;
  typedef logic [31:0]                  undo_log_addr_t;
  typedef logic [31:0]                  undo_log_data_t;
  typedef logic [LOG_CQ_SLICE_SIZE-1:0] cq_slice_slot_t;

  typedef struct packed {
    cq_slice_slot_t slot;
    undo_id_t       id;
    undo_log_addr_t addr;
    undo_log_data_t data;
  } undo_log_entry_t;

  // Index width for a set of n requesters, never narrower than one bit.
  function automatic int core_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/undo_log_arbiter_if.sv
// Core-side undo-log ports, undo RAM write port and status of one tile arbiter.
interface undo_log_arbiter_if #(
  parameter int N_CORES        = 4,
  parameter int LOG_UNDO_DEPTH = undo_log_arbiter_pkg::LOG_UNDO_LOG_DEPTH
) ();
  import undo_log_arbiter_pkg::*;

  localparam int CORE_W = core_w(N_CORES);
  localparam int IDX_W  = LOG_CQ_SLICE_SIZE + LOG_UNDO_DEPTH;

  // Every channel is valid/ready: a transfer happens on a rising clk edge where
  // both are high; the sender holds its payload stable while valid & !ready.
  logic           [N_CORES-1:0] in_valid;
  logic           [N_CORES-1:0] in_ready;
  undo_id_t       [N_CORES-1:0] in_id;
  undo_log_addr_t [N_CORES-1:0] in_addr;
  undo_log_data_t [N_CORES-1:0] in_data;
  cq_slice_slot_t [N_CORES-1:0] in_slot;

  logic                         mem_wvalid;
  logic                         mem_wready;
  logic           [IDX_W-1:0]   mem_windex;
  undo_log_addr_t               mem_waddr;
  undo_log_data_t               mem_wdata;
  logic           [CORE_W-1:0]  mem_wcore;

  logic                         overflow;
  logic           [CORE_W-1:0]  overflow_core;
  logic           [31:0]        num_writes;

  modport master (
    output in_valid, in_id, in_addr, in_data, in_slot, mem_wready,
    input  in_ready, mem_wvalid, mem_windex, mem_waddr, mem_wdata, mem_wcore,
    input  overflow, overflow_core, num_writes
  );

  modport slave (
    input  in_valid, in_id, in_addr, in_data, in_slot, mem_wready,
    output in_ready, mem_wvalid, mem_windex, mem_waddr, mem_wdata, mem_wcore,
    output overflow, overflow_core, num_writes
  );

endinterface

// File: rtl/undo_log_arbiter_rr_arbiter.sv
// N-way round-robin arbiter: combinational grant, pointer advances past each taken grant.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic          gnt_valid_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   cand;

  // Scan offsets high to low so the nearest requester at or after ptr_q wins.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    cand        = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (IW + 1)'(k);
      if (cand >= (IW + 1)'(N)) cand = cand - (IW + 1)'(N);
      if (req_i[cand[IW-1:0]]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && gnt_valid_o)
      ptr_d = (gnt_idx_o == IW'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/undo_log_arbiter.sv
// Per-core skid registers feeding one round-robin arbitrated undo-log RAM write port,
// with sticky detection of entries whose id exceeds the per-slot log depth.
module undo_log_arbiter
  import undo_log_arbiter_pkg::*;
#(
  parameter int N_CORES        = 4,
  parameter int LOG_UNDO_DEPTH = LOG_UNDO_LOG_DEPTH,
  parameter int TILE_ID        = 0
) (
  input  logic              clk,
  input  logic              rstn,
  undo_log_arbiter_if.slave bus
);

  localparam int       CW       = core_w(N_CORES);
  localparam int       IDX_W    = LOG_CQ_SLICE_SIZE + LOG_UNDO_DEPTH;
  localparam undo_id_t ID_LIMIT = undo_id_t'(2 ** LOG_UNDO_DEPTH);

  logic            [N_CORES-1:0] skid_valid_q, skid_valid_d;
  undo_log_entry_t               skid_q [N_CORES];
  logic            [N_CORES-1:0] cap, store;
  logic                          ovf_hit;
  logic            [CW-1:0]      ovf_idx;

  logic                          gnt_valid, load;
  logic            [CW-1:0]      gnt_idx;

  logic                          wvalid_q, wvalid_d;
  logic            [IDX_W-1:0]   windex_q;
  undo_log_addr_t                waddr_q;
  undo_log_data_t                wdata_q;
  logic            [CW-1:0]      wcore_q;

  logic                          ovf_q, ovf_d;
  logic            [CW-1:0]      ovf_core_q, ovf_core_d;
  logic            [31:0]        num_writes_q, num_writes_d;

  // Ready depends only on skid occupancy, so a skid emptied by a grant refills a cycle later.
  assign bus.in_ready = ~skid_valid_q;
  assign cap          = bus.in_valid & ~skid_valid_q;
  assign load         = gnt_valid & (~wvalid_q | bus.mem_wready);

  // Out-of-range ids complete their handshake but never occupy the skid.
  always_comb begin
    store   = '0;
    ovf_hit = 1'b0;
    ovf_idx = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (cap[i] && (bus.in_id[i] >= ID_LIMIT)) begin
        ovf_hit = 1'b1;
        ovf_idx = CW'(i);
      end
      store[i] = cap[i] && (bus.in_id[i] < ID_LIMIT);
    end
  end

  rr_arbiter #(.N(N_CORES)) u_rr (
    .clk_i       (clk),
    .rst_ni      (rstn),
    .req_i       (skid_valid_q),
    .advance_i   (load),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  always_comb begin
    skid_valid_d = skid_valid_q;
    if (load) skid_valid_d[gnt_idx] = 1'b0;
    skid_valid_d = skid_valid_d | store;

    wvalid_d = wvalid_q;
    if (load)                wvalid_d = 1'b1;
    else if (bus.mem_wready) wvalid_d = 1'b0;

    num_writes_d = num_writes_q + ((wvalid_q && bus.mem_wready) ? 32'd1 : 32'd0);
    ovf_d        = ovf_q | ovf_hit;
    ovf_core_d   = (ovf_hit && !ovf_q) ? ovf_idx : ovf_core_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      skid_valid_q <= '0;
      wvalid_q     <= 1'b0;
      ovf_q        <= 1'b0;
      ovf_core_q   <= '0;
      num_writes_q <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      wvalid_q     <= wvalid_d;
      ovf_q        <= ovf_d;
      ovf_core_q   <= ovf_core_d;
      num_writes_q <= num_writes_d;
    end
  end

  // Payload registers carry no reset; their valid bits decide whether they mean anything.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CORES; i++) begin
      if (store[i])
        skid_q[i] <= '{slot: bus.in_slot[i], id: bus.in_id[i],
                       addr: bus.in_addr[i], data: bus.in_data[i]};
    end
    if (load) begin
      windex_q <= {skid_q[gnt_idx].slot, skid_q[gnt_idx].id[LOG_UNDO_DEPTH-1:0]};
      waddr_q  <= skid_q[gnt_idx].addr;
      wdata_q  <= skid_q[gnt_idx].data;
      wcore_q  <= gnt_idx;
    end
  end

  assign bus.mem_wvalid    = wvalid_q;
  assign bus.mem_windex    = windex_q;
  assign bus.mem_waddr     = waddr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wcore     = wcore_q;
  assign bus.overflow      = ovf_q;
  assign bus.overflow_core = ovf_core_q;
  assign bus.num_writes    = num_writes_q;

endmodule

// File: tb/tb_undo_log_arbiter.sv
// Directed and randomized checks of undo_log_arbiter against a per-core queue scoreboard.
`timescale 1ns/1ps
module tb_undo_log_arbiter;
  import undo_log_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int LD = 2;
  localparam int EW = LOG_CQ_SLICE_SIZE + LD + 64;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  undo_log_arbiter_if #(.N_CORES(N), .LOG_UNDO_DEPTH(LD)) bus ();

  undo_log_arbiter #(.N_CORES(N), .LOG_UNDO_DEPTH(LD), .TILE_ID(0)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // One queue per core: entries must reach memory in the order that core handed them over.
  logic [EW-1:0] exp_q [N][$];
  int            writes_exp   = 0;
  logic          ovf_exp      = 1'b0;
  int            ovf_core_exp = 0;
  int            wc;

  function automatic int pending();
    int s = 0;
    for (int c = 0; c < N; c++) s += exp_q[c].size();
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rstn) begin
      for (int c = 0; c < N; c++) exp_q[c].delete();
      writes_exp   = 0;
      ovf_exp      = 1'b0;
      ovf_core_exp = 0;
    end else begin
      chk("num_writes", EW'(bus.num_writes), EW'(writes_exp));
      chk("overflow", EW'(bus.overflow), EW'(ovf_exp));
      chk("overflow_core", EW'(bus.overflow_core), EW'(ovf_core_exp));
      for (int c = 0; c < N; c++) begin
        if (bus.in_valid[c] && bus.in_ready[c]) begin
          if (bus.in_id[c] >= undo_id_t'(1 << LD)) begin
            if (!ovf_exp) begin
              ovf_exp      = 1'b1;
              ovf_core_exp = c;
            end
          end else begin
            exp_q[c].push_back({bus.in_slot[c], bus.in_id[c][LD-1:0], bus.in_addr[c], bus.in_data[c]});
          end
        end
      end
      if (bus.mem_wvalid && bus.mem_wready) begin
        wc = int'(bus.mem_wcore);
        chk("write_has_entry", EW'(exp_q[wc].size() != 0), EW'(1));
        if (exp_q[wc].size() != 0)
          chk("write_entry", {bus.mem_windex, bus.mem_waddr, bus.mem_wdata}, exp_q[wc].pop_front());
        writes_exp++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of valid/ready driving: drop valid on every core whose handshake completed.
  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = bus.in_valid & bus.in_ready;
    @(posedge clk);
    #1;
    bus.in_valid = bus.in_valid & ~acc;
  endtask

  task automatic put(input int c, input int slot, input int id, input logic [31:0] addr,
                     input logic [31:0] data);
    bus.in_valid[c] = 1'b1;
    bus.in_slot[c]  = cq_slice_slot_t'(slot);
    bus.in_id[c]    = undo_id_t'(id);
    bus.in_addr[c]  = addr;
    bus.in_data[c]  = data;
  endtask

  task automatic do_reset();
    bus.in_valid   = '0;
    bus.mem_wready = 1'b0;
    rstn = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic drain(input string tag);
    int w;
    bus.mem_wready = 1'b1;
    for (w = 0; w < 100 && bus.in_valid != '0; w++) step();
    chk({tag, "_accept"}, EW'(bus.in_valid), EW'(0));
    for (w = 0; w < 100; w++) begin
      tick();
      if (pending() == 0 && !bus.mem_wvalid) break;
    end
    chk({tag, "_pending"}, EW'(pending()), EW'(0));
    chk({tag, "_wvalid"}, EW'(bus.mem_wvalid), EW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    bus.in_valid   = '0;
    bus.in_id      = '0;
    bus.in_addr    = '0;
    bus.in_data    = '0;
    bus.in_slot    = '0;
    bus.mem_wready = 1'b0;
    do_reset();

    chk("rst_wvalid", EW'(bus.mem_wvalid), EW'(0));
    chk("rst_in_ready", EW'(bus.in_ready), EW'(4'hF));
    chk("rst_num_writes", EW'(bus.num_writes), EW'(0));
    chk("rst_overflow", EW'(bus.overflow), EW'(0));

    // single entry, two-cycle latency
    put(0, 5, 1, 32'h1000, 32'hAB);
    bus.mem_wready = 1'b1;
    tick();
    bus.in_valid = '0;
    chk("t1_ready_busy", EW'(bus.in_ready), EW'(4'hE));
    chk("t1_wvalid_early", EW'(bus.mem_wvalid), EW'(0));
    tick();
    chk("t1_wvalid", EW'(bus.mem_wvalid), EW'(1));
    chk("t1_windex", EW'(bus.mem_windex), EW'(21));
    chk("t1_waddr", EW'(bus.mem_waddr), EW'(32'h1000));
    chk("t1_wdata", EW'(bus.mem_wdata), EW'(32'hAB));
    chk("t1_wcore", EW'(bus.mem_wcore), EW'(0));
    chk("t1_ready_back", EW'(bus.in_ready), EW'(4'hF));
    tick();
    chk("t1_num_writes", EW'(bus.num_writes), EW'(1));
    chk("t1_wvalid_fall", EW'(bus.mem_wvalid), EW'(0));

    // all cores at once from a reset pointer
    do_reset();
    bus.mem_wready = 1'b1;
    for (int c = 0; c < N; c++) put(c, 8 + c, 0, 32'h2000 + c, 32'h20 + c);
    tick();
    bus.in_valid = '0;
    chk("t2_ready_busy", EW'(bus.in_ready), EW'(4'h0));
    for (int c = 0; c < N; c++) begin
      tick();
      chk("t2_wvalid", EW'(bus.mem_wvalid), EW'(1));
      chk("t2_grant_order", EW'(bus.mem_wcore), EW'(c));
    end
    tick();
    chk("t2_wvalid_fall", EW'(bus.mem_wvalid), EW'(0));
    chk("t2_num_writes", EW'(bus.num_writes), EW'(4));

    // backpressure with two entries pending
    bus.mem_wready = 1'b0;
    put(1, 6, 2, 32'h3001, 32'h31);
    put(2, 7, 3, 32'h3002, 32'h32);
    tick();
    bus.in_valid = '0;
    tick();
    chk("t3_first_core", EW'(bus.mem_wcore), EW'(1));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_valid", EW'(bus.mem_wvalid), EW'(1));
      chk("t3_hold_core", EW'(bus.mem_wcore), EW'(1));
      chk("t3_hold_windex", EW'(bus.mem_windex), EW'(26));
      chk("t3_hold_waddr", EW'(bus.mem_waddr), EW'(32'h3001));
      chk("t3_hold_ready", EW'(bus.in_ready), EW'(4'hB));
    end
    bus.mem_wready = 1'b1;
    tick();
    chk("t3_second_valid", EW'(bus.mem_wvalid), EW'(1));
    chk("t3_second_core", EW'(bus.mem_wcore), EW'(2));
    chk("t3_second_windex", EW'(bus.mem_windex), EW'(31));
    tick();
    chk("t3_wvalid_fall", EW'(bus.mem_wvalid), EW'(0));
    chk("t3_num_writes", EW'(bus.num_writes), EW'(6));

    // overflow from core 2, then a later one from core 1
    put(2, 1, 4, 32'h4000, 32'h44);
    tick();
    bus.in_valid = '0;
    chk("t4_overflow", EW'(bus.overflow), EW'(1));
    chk("t4_overflow_core", EW'(bus.overflow_core), EW'(2));
    chk("t4_ready_kept", EW'(bus.in_ready), EW'(4'hF));
    repeat (2) tick();
    chk("t4_no_write", EW'(bus.mem_wvalid), EW'(0));
    chk("t4_num_writes", EW'(bus.num_writes), EW'(6));
    put(1, 2, 7, 32'h4100, 32'h45);
    tick();
    bus.in_valid = '0;
    chk("t4_overflow_core_kept", EW'(bus.overflow_core), EW'(2));
    tick();
    chk("t4_no_write2", EW'(bus.mem_wvalid), EW'(0));

    // same-core ordering under random mem_wready
    for (int i = 0; i < 3; i++) begin
      put(3, 9, i, 32'h5000 + i, 32'h50 + i);
      for (int w = 0; w < 100 && bus.in_valid[3]; w++) begin
        bus.mem_wready = 1'($urandom_range(0, 1));
        step();
      end
      chk("t5_accept", EW'(bus.in_valid[3]), EW'(0));
    end
    drain("t5_drain");
    chk("t5_num_writes", EW'(bus.num_writes), EW'(9));

    // reset while two skids and the output register hold entries
    bus.mem_wready = 1'b0;
    put(0, 2, 0, 32'h6000, 32'h60);
    put(1, 2, 1, 32'h6001, 32'h61);
    put(2, 2, 2, 32'h6002, 32'h62);
    tick();
    bus.in_valid = '0;
    tick();
    chk("t6_out_valid", EW'(bus.mem_wvalid), EW'(1));
    chk("t6_skids_busy", EW'(bus.in_ready), EW'(4'h9));
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_async_wvalid", EW'(bus.mem_wvalid), EW'(0));
    chk("t6_async_ready", EW'(bus.in_ready), EW'(4'hF));
    repeat (2) tick();
    rstn = 1'b1;
    bus.mem_wready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_no_write", EW'(bus.mem_wvalid), EW'(0));
    end
    chk("t6_num_writes", EW'(bus.num_writes), EW'(0));
    chk("t6_overflow", EW'(bus.overflow), EW'(0));
    chk("t6_overflow_core", EW'(bus.overflow_core), EW'(0));

    // simultaneous overflows record the lowest core
    put(3, 3, 5, 32'h7003, 32'h73);
    put(1, 3, 6, 32'h7001, 32'h71);
    put(0, 15, 3, 32'h7000, 32'h70);
    tick();
    bus.in_valid = '0;
    chk("t7_overflow", EW'(bus.overflow), EW'(1));
    chk("t7_lowest_core", EW'(bus.overflow_core), EW'(1));
    drain("t7_drain");
    chk("t7_num_writes", EW'(bus.num_writes), EW'(1));

    // randomized traffic on all cores with random backpressure
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (!bus.in_valid[c] && $urandom_range(0, 99) < 60) begin
          put(c, int'($urandom_range(0, 15)),
              ($urandom_range(0, 19) == 0) ? int'($urandom_range(4, 255)) : int'($urandom_range(0, 3)),
              $urandom, $urandom);
        end
      end
      bus.mem_wready = ($urandom_range(0, 99) < 70);
      step();
    end
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/undo_log_arbiter.md
Name: undo_log_arbiter

Overview:
- Sits directly downstream of the per-core undo-log write ports within a tile.
- Collects undo-log entries (address, old data) from N_CORES cores through a one-entry skid register per core.
- Arbitrates round-robin among them and issues single writes into the tile's undo-log RAM at index {cq_slot, undo_id}.
- Detects entries whose undo_id exceeds the per-slot log depth and flags them as a sticky overflow error.

Parameters:
- N_CORES, 4, number of core undo-log inputs (1..16).
- LOG_UNDO_DEPTH, 2, log2 of undo-log entries per CQ slot.
- TILE_ID, 0, tile index, used only in debug display.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  N_CORES  per-core undo_log_valid
- in_ready  out  N_CORES  per-core undo_log_ready
- in_id  in  N_CORES x undo_id_t  per-core undo_log_id
- in_addr  in  N_CORES x undo_log_addr_t  per-core logged address
- in_data  in  N_CORES x undo_log_data_t  per-core old data
- in_slot  in  N_CORES x cq_slice_slot_t  per-core owning CQ slot
- mem_wvalid  out  1  undo RAM write request
- mem_wready  in  1  undo RAM accepts write
- mem_windex  out  LOG_CQ_SLICE_SIZE+LOG_UNDO_DEPTH  {slot, id[LOG_UNDO_DEPTH-1:0]}
- mem_waddr  out  undo_log_addr_t  logged address
- mem_wdata  out  undo_log_data_t  logged old data
- mem_wcore  out  log2(N_CORES) min 1  source core, debug/stats only
- overflow  out  1  sticky: an entry with id >= 2**LOG_UNDO_DEPTH was dropped
- overflow_core  out  log2(N_CORES) min 1  core of first overflow
- num_writes  out  32  count of mem writes accepted

Behaviour:
- Reset (rstn low, async): all skid valids 0, in_ready all 1 on the first cycle after release, mem_wvalid 0, overflow 0, overflow_core 0, num_writes 0, rr pointer 0.
  - Data registers are not reset.
  - Reset mid-operation discards all buffered entries, with no write issued.
- Skid stage, per core i:
  - in_ready[i] = !skid_valid[i]. This is combinational from the register only, with no path from in_valid.
  - On in_valid[i] & in_ready[i]: capture id/addr/data/slot, set skid_valid[i] next cycle.
  - Input-to-skid latency: 1 cycle.
- Overflow check at capture:
  - Condition: in_id[i] >= 2**LOG_UNDO_DEPTH.
  - The entry is accepted (handshake completes) but not stored; skid_valid stays 0.
  - overflow is set to 1. overflow_core gets i only if overflow was 0 before.
  - If several cores overflow in the same cycle, the lowest index is recorded.
- Output register:
  - out_free = !mem_wvalid | mem_wready.
  - When out_free and any skid_valid is set:
    - Grant the first valid core at or after rr_ptr (wrapping modulo N_CORES).
    - Load mem_* from that skid and clear its skid_valid.
    - Set rr_ptr to grant+1 (wrapping from N_CORES-1 to 0).
  - Otherwise, if mem_wready, mem_wvalid falls to 0.
  - mem_* stays stable while mem_wvalid & !mem_wready.
- Minimum latency: core handshake to mem_wvalid is 2 cycles.
- Sustained throughput: 1 write/cycle when mem_wready is held high.
- A skid cleared by a grant may accept a new input the next cycle, not the same cycle.
- num_writes increments on each mem_wvalid & mem_wready and wraps at 2**32.
- Ordering: entries from one core reach memory in arrival order. This holds because the skid depth is 1.
- No ordering is guaranteed across cores. None is needed, because the index is unique per (slot, id).
- DEBUG builds: $display each write with cycle, tile, core, slot, id, addr, data; $display on the first overflow.

Decomposition:
- chronos package: undo_id_t, undo_log_addr_t, undo_log_data_t, cq_slice_slot_t, LOG_CQ_SLICE_SIZE, and new constant LOG_UNDO_LOG_DEPTH (default for LOG_UNDO_DEPTH).
- New package typedef undo_log_entry_t: struct {slot, id, addr, data}.
- One natural sub-module: rr_arbiter (N-request round-robin, combinational grant plus registered pointer). It is reusable for task-enqueue arbitration.

Test Plan:
- Single entry: core 0 sends slot 5, id 1, addr 0x1000, data 0xAB with mem_wready=1.
  - Required: mem_wvalid 2 cycles later, windex {5,1}, num_writes=1, in_ready[0] high again the following cycle.
- All 4 cores valid in the same cycle (ids 0), rr_ptr 0, mem_wready=1.
  - Required: grants 0,1,2,3 on consecutive cycles, then mem_wvalid 0.
- Backpressure: mem_wready=0 for 5 cycles with 2 entries pending.
  - Required: mem_* holds the first entry unchanged and the in_ready of a still-buffered core stays 0.
  - On release: 2 writes in consecutive cycles.
- Overflow with LOG_UNDO_DEPTH=2: core 2 sends id 4.
  - Required: handshake completes, no mem write, overflow=1, overflow_core=2.
  - A later overflow from core 1 leaves overflow_core=2.
- Same-core ordering: core 3 sends ids 0,1,2 back-to-back under random mem_wready.
  - Required: memory sees ids 0,1,2 in order and no in_ready violation occurs.
- Reset mid-operation: rstn low while 2 skids and the output are valid.
  - Required: mem_wvalid 0 immediately (async), no write after release, counters 0.
